// File: rtl/lp_buffer_mc.sv
// Ping-pong packet delay buffer: each stored packet is replayed while the
// next one is written (paced by its strobes) or freely after it closes.
module lp_buffer_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_CH     = 4,
    parameter int RD_MODE    = 0
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_wr_data,
    input  logic                         i_wr_wen,
    input  logic                         i_wr_vld,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_rd_data,
    output logic                         o_rd_vld,
    output logic                         o_rd_sop,
    output logic                         o_rd_eop,
    output logic [ADDR_WIDTH:0]          o_rd_len,
    output logic                         o_wr_ovf,
    output logic                         o_rd_abort
);

    localparam int W = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam bit FREE = (RD_MODE != 0);

    typedef enum logic {WR_IDLE, WR_PKT} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_ACTIVE} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH:0] rd_len_q, rd_len_d;
    logic                wr_bank_q, wr_bank_d;

    logic [W-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];
    logic [W-1:0] ram_q;

    logic vld1_q, sop1_q, eop1_q, abort1_q;
    logic [ADDR_WIDTH:0] len1_q;
    logic [W-1:0] data_q;
    logic vld_q, sop_q, eop_q, abort_q, ovf_q;
    logic [ADDR_WIDTH:0] len_q;

    logic strobe, close, wr_en, ovf_d, issue, last, abort_d;
    logic [ADDR_WIDTH:0] wr_base, wr_inc;

    assign strobe  = i_wr_vld & i_wr_wen;
    assign close   = (wr_state_q == WR_PKT) & ~i_wr_vld;
    // First word of a packet lands at address 0 before the counter clears
    assign wr_base = (wr_state_q == WR_IDLE) ? '0 : wr_cnt_q;
    assign wr_en   = strobe & (wr_base != DEPTH);
    assign ovf_d   = strobe & (wr_base == DEPTH);
    assign wr_inc  = {{ADDR_WIDTH{1'b0}}, wr_en};

    assign issue   = (rd_state_q != RD_IDLE) & (FREE ? 1'b1 : strobe);
    assign last    = (rd_cnt_q == rd_len_q - ONE);
    assign abort_d = close & (rd_state_q == RD_ACTIVE) & ~(issue & last);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (i_wr_vld) begin
                    wr_state_d = WR_PKT;
                    wr_cnt_d   = wr_inc;
                end
            end
            WR_PKT: begin
                if (!i_wr_vld) begin
                    wr_state_d = WR_IDLE;
                    if (wr_cnt_q != '0) wr_bank_d = ~wr_bank_q;
                end else begin
                    wr_cnt_d = wr_cnt_q + wr_inc;
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_len_d   = rd_len_q;
        if (issue) begin
            rd_cnt_d   = rd_cnt_q + ONE;
            rd_state_d = last ? RD_IDLE : RD_ACTIVE;
        end
        // A close always overrides the replay in progress
        if (close) begin
            if (wr_cnt_q != '0) begin
                rd_state_d = FREE ? RD_ACTIVE : RD_WAIT;
                rd_cnt_d   = '0;
                rd_len_d   = wr_cnt_q;
            end else begin
                rd_state_d = RD_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[{wr_bank_q, wr_base[ADDR_WIDTH-1:0]}] <= i_wr_data;
        ram_q <= mem[{~wr_bank_q, rd_cnt_q[ADDR_WIDTH-1:0]}];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_len_q   <= '0;
            wr_bank_q  <= 1'b0;
            vld1_q     <= 1'b0;
            sop1_q     <= 1'b0;
            eop1_q     <= 1'b0;
            abort1_q   <= 1'b0;
            len1_q     <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            abort_q    <= 1'b0;
            ovf_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_len_q   <= rd_len_d;
            wr_bank_q  <= wr_bank_d;
            vld1_q     <= issue;
            sop1_q     <= issue & (rd_cnt_q == '0);
            eop1_q     <= issue & last;
            abort1_q   <= abort_d;
            len1_q     <= rd_len_q;
            vld_q      <= vld1_q;
            sop_q      <= sop1_q;
            eop_q      <= eop1_q;
            abort_q    <= abort1_q;
            ovf_q      <= ovf_d;
            if (vld1_q) data_q <= ram_q;
            if (vld1_q & sop1_q) len_q <= len1_q;
        end
    end

    assign o_rd_data  = data_q;
    assign o_rd_vld   = vld_q;
    assign o_rd_sop   = sop_q;
    assign o_rd_eop   = eop_q;
    assign o_rd_len   = len_q;
    assign o_wr_ovf   = ovf_q;
    assign o_rd_abort = abort_q;

endmodule

// File: tb/tb_lp_buffer_mc.sv
// Bench for lp_buffer_mc: paced (mode 0) and free-running (mode 1) copies
// share one input stream; each is checked against a packet-level model.
module tb_lp_buffer_mc;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int NC    = 4;
    localparam int W     = DW * NC;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wr_vld, wr_wen;
    logic [W-1:0]  wr_data;
    logic [1:0][W-1:0]  rd_data;
    logic [1:0][AW:0]   rd_len;
    logic [1:0]    rd_vld, rd_sop, rd_eop, wr_ovf, rd_abort;

    lp_buffer_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .RD_MODE(0)) u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr_data(wr_data),
        .i_wr_wen(wr_wen), .i_wr_vld(wr_vld),
        .o_rd_data(rd_data[0]), .o_rd_vld(rd_vld[0]), .o_rd_sop(rd_sop[0]),
        .o_rd_eop(rd_eop[0]), .o_rd_len(rd_len[0]), .o_wr_ovf(wr_ovf[0]),
        .o_rd_abort(rd_abort[0])
    );

    lp_buffer_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .RD_MODE(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr_data(wr_data),
        .i_wr_wen(wr_wen), .i_wr_vld(wr_vld),
        .o_rd_data(rd_data[1]), .o_rd_vld(rd_vld[1]), .o_rd_sop(rd_sop[1]),
        .o_rd_eop(rd_eop[1]), .o_rd_len(rd_len[1]), .o_wr_ovf(wr_ovf[1]),
        .o_rd_abort(rd_abort[1])
    );

    typedef struct packed {
        logic         v, s, e, a;
        logic [AW:0]  len;
        logic [W-1:0] d;
    } exp_t;

    // Model: the stored packet awaiting/under replay and the packet being written
    exp_t         e1 [2];
    exp_t         e2 [2];
    logic         ov1;
    logic [W-1:0] rbuf [2][DEPTH];
    logic [W-1:0] cur [DEPTH];
    int           rlen [2];
    int           rpos [2];
    bit           rex [2];
    bit           rgo [2];
    int           cur_n;
    bit           in_pkt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e1[m] = '0; e2[m] = '0;
            rex[m] = 0; rgo[m] = 0; rlen[m] = 0; rpos[m] = 0;
        end
        ov1 = 0; cur_n = 0; in_pkt = 0;
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d vld", m), W'(rd_vld[m]), W'(e2[m].v));
            chk($sformatf("m%0d sop", m), W'(rd_sop[m]), W'(e2[m].s));
            chk($sformatf("m%0d eop", m), W'(rd_eop[m]), W'(e2[m].e));
            chk($sformatf("m%0d abort", m), W'(rd_abort[m]), W'(e2[m].a));
            chk($sformatf("m%0d ovf", m), W'(wr_ovf[m]), W'(ov1));
            if (e2[m].v) begin
                chk($sformatf("m%0d data", m), rd_data[m], e2[m].d);
                chk($sformatf("m%0d len", m), W'(rd_len[m]), W'(e2[m].len));
            end
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [W-1:0] d);
        exp_t it;
        bit strobe = v & w;
        bit close  = in_pkt & !v;
        bit ov     = 0;
        for (int m = 0; m < 2; m++) begin
            it = '0;
            if (rex[m] && ((m == 0 && strobe) || (m == 1 && rgo[m]))) begin
                it.v   = 1;
                it.d   = rbuf[m][rpos[m]];
                it.s   = (rpos[m] == 0);
                it.e   = (rpos[m] == rlen[m] - 1);
                it.len = (AW+1)'(rlen[m]);
                rgo[m] = 1;
                rpos[m]++;
                if (rpos[m] == rlen[m]) rex[m] = 0;
            end
            if (close) begin
                it.a = rex[m] && rgo[m];
                rex[m] = (cur_n > 0);
                rlen[m] = cur_n;
                rpos[m] = 0;
                rgo[m] = (m == 1);
                for (int i = 0; i < DEPTH; i++) rbuf[m][i] = cur[i];
            end
            e2[m] = e1[m];
            e1[m] = it;
        end
        if (v) begin
            if (!in_pkt) cur_n = 0;
            if (w) begin
                if (cur_n < DEPTH) begin
                    cur[cur_n] = d;
                    cur_n++;
                end else begin
                    ov = 1;
                end
            end
        end
        in_pkt = v;
        ov1 = ov;
    endtask

    task automatic cyc(input logic v, input logic w, input logic [W-1:0] d);
        @(negedge clk);
        compare_all();
        wr_vld = v; wr_wen = w; wr_data = d;
        step(v, w, d);
    endtask

    task automatic gap(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, rnd());
    endtask

    // n strobes, one every sp cycles, inside one vld window
    task automatic pkt(input int n, input int sp);
        if (n == 0) cyc(1'b1, 1'b0, rnd());
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, rnd());
            for (int j = 1; j < sp; j++) cyc(1'b1, 1'b0, rnd());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_vld = 1'b0; wr_wen = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d rst vld", m), W'(rd_vld[m]), '0);
            chk($sformatf("m%0d rst sop", m), W'(rd_sop[m]), '0);
            chk($sformatf("m%0d rst eop", m), W'(rd_eop[m]), '0);
            chk($sformatf("m%0d rst abort", m), W'(rd_abort[m]), '0);
            chk($sformatf("m%0d rst ovf", m), W'(wr_ovf[m]), '0);
            chk($sformatf("m%0d rst data", m), rd_data[m], '0);
            chk($sformatf("m%0d rst len", m), W'(rd_len[m]), '0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0; wr_vld = 1'b0; wr_wen = 1'b0; wr_data = '0;
        model_reset();
        do_reset();
        gap(2);

        pkt(8, 1); gap(2); pkt(8, 1); gap(12);
        pkt(8, 1); gap(1); pkt(5, 1); gap(2); pkt(5, 1); gap(12);
        pkt(3, 1); gap(6);
        pkt(10, 1); gap(2); pkt(10, 1); gap(12);
        pkt(6, 4); gap(2); pkt(6, 4); gap(10);
        pkt(1, 1); gap(1); pkt(1, 1); gap(1); pkt(0, 1); gap(5);
        pkt(8, 1); gap(1); pkt(0, 1); gap(1); pkt(4, 2); gap(10);

        pkt(8, 1); gap(1); pkt(3, 1);
        do_reset();
        pkt(5, 1); gap(2); pkt(5, 1); gap(2); pkt(2, 1); gap(10);

        for (int k = 0; k < 60; k++) begin
            int n  = $urandom_range(0, 11);
            int sp = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) do_reset();
            pkt(n, sp);
            gap($urandom_range(1, 4));
        end
        gap(14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lp_buffer_mc.md
LP_BUFFER_MC -- requirements
Module: lp_buffer_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per channel word.
REQ-002 Parameter ADDR_WIDTH, default 6: bank address width; DEPTH = 2**ADDR_WIDTH words per bank.
REQ-003 Parameter NUM_CH, default 4: channels stored side by side in one word, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-004 Parameter RD_MODE, default 0: 0 = read paced by the next packet's write strobes; 1 = free-running read, one word per cycle.
REQ-005 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 i_reset_n  in  1  reset, asynchronous assert, active-low; synchronous release.
REQ-007 i_wr_data  in  NUM_CH*DATA_WIDTH  write word, all channels.
REQ-008 i_wr_wen  in  1  write strobe, honoured only while i_wr_vld=1.
REQ-009 i_wr_vld  in  1  packet window; one contiguous high run = one packet.
REQ-010 o_rd_data  out  NUM_CH*DATA_WIDTH  delayed word.
REQ-011 o_rd_vld  out  1  o_rd_data valid.
REQ-012 o_rd_sop / o_rd_eop  out  1 each  first / last word of a replayed packet.
REQ-013 o_rd_len  out  ADDR_WIDTH+1  stored length of the packet being replayed, held from sop through eop.
REQ-014 o_wr_ovf  out  1  one-cycle pulse: write dropped because the bank is full.
REQ-015 o_rd_abort  out  1  one-cycle pulse: replay cut short before eop.

Function
REQ-016 Two banks (ping-pong), each DEPTH x NUM_CH*DATA_WIDTH; write bank and read bank are always different banks.
REQ-017 Write FSM has two states: WR_IDLE and WR_PKT. WR_IDLE->WR_PKT on i_wr_vld=1. WR_PKT->WR_IDLE on i_wr_vld=0 ("close").
REQ-018 Each cycle with i_wr_vld=1 and i_wr_wen=1 writes i_wr_data at wr_addr; wr_addr then increments. wr_addr is cleared to 0 on entry to WR_PKT.
REQ-019 Writes arriving after DEPTH words are stored are dropped, each with one o_wr_ovf pulse in the following cycle. The stored length saturates at DEPTH.
REQ-020 On close, with stored length L: if L>0, the write bank becomes the ready bank with length L and the bank roles swap. If L=0, no swap and no ready bank is created.
REQ-021 Read FSM has three states: RD_IDLE (no ready bank), RD_WAIT (ready, no replay started), RD_ACTIVE (replaying). A close with L>0 takes any state to RD_WAIT (RD_MODE=0) or to RD_ACTIVE (RD_MODE=1).
REQ-022 RD_MODE=0: in RD_WAIT, the first write strobe of the next packet enters RD_ACTIVE. In RD_ACTIVE, each write strobe (i_wr_vld&i_wr_wen) issues one read, up to L reads. Write strobes beyond L produce no output.
REQ-023 RD_MODE=1: in RD_ACTIVE, one read is issued per cycle, starting the cycle after close, for L consecutive cycles.
REQ-024 Read latency: o_rd_vld is asserted exactly 2 cycles after the cycle a read is issued (registered RAM output, then output register). o_rd_data is registered.
REQ-025 o_rd_sop accompanies word 0 and o_rd_eop accompanies word L-1; both are asserted on the same word when L=1. After eop is issued, the FSM goes to RD_IDLE.
REQ-026 A close while in RD_ACTIVE with fewer than L reads issued aborts the replay. Remaining words are discarded, no eop is emitted, o_rd_abort pulses 2 cycles after the close, and the new ready bank is taken per REQ-021.
REQ-027 RD_MODE=0: a close in RD_WAIT (next packet had no strobes) discards the old ready bank without any pulse.
REQ-028 Data order: words replay in write order with no gaps in RD_MODE=1. All channels are delayed identically.
REQ-029 i_wr_vld toggling while i_wr_wen=0 produces zero-length packets per REQ-020. These packets abort an active replay.

Reset
REQ-030 When i_reset_n=0, asynchronously: all outputs go to 0, both FSMs go to idle, addresses and lengths go to 0, and no bank is ready. RAM contents are don't-care.
REQ-031 Reset asserted mid-packet or mid-replay discards all state; the first packet after release produces no output.

Verification
REQ-032 RD_MODE=0, NUM_CH=4: packet A of 8 words, then packet B of 8 words -> A0..A7 out, each 2 cycles after B's strobes, sop with A0, eop with A7, o_rd_len=8.
REQ-033 RD_MODE=0: A of 8 words, then B of 5 words -> A0..A4 out, o_rd_abort 2 cycles after B closes, no eop. C after B -> B0..B4 out.
REQ-034 RD_MODE=1: A of 3 words closes -> A0,A1,A2 on 3 consecutive cycles starting 3 cycles after the close cycle, sop/eop correct.
REQ-035 ADDR_WIDTH=3: a packet of 10 words -> 2 o_wr_ovf pulses, stored length 8, and the replay emits words 0..7 only.
REQ-036 Reset pulsed during a replay -> outputs 0 immediately; the next packet produces no output and the following packet replays it.
REQ-037 Sparse strobes (one every 4 cycles), RD_MODE=0 -> output spacing follows the strobes with a constant 2-cycle lag.
